spi_master_param: RTL and testbench
===================================

SPI_MASTER_PARAM -- requirements
Module: spi_master_param

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, bits per transfer (range 2..32).
REQ-002 SHALL provide parameter CLK_DIV, default 13, clk cycles per sck half-period (minimum 1).
REQ-003 SHALL provide parameter NUM_CS, default 4, number of chip-select outputs (range 1..8).
REQ-004 SHALL provide port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL provide port rst  input  1  synchronous active-high reset.
REQ-006 SHALL provide port start  input  1  transfer request, sampled only in IDLE.
REQ-007 SHALL provide port data_in  input  DATA_WIDTH  transmit word.
REQ-008 SHALL provide port cs_sel  input  $clog2(NUM_CS) (min 1)  target slave index.
REQ-009 SHALL provide port cpol  input  1  sck idle level.
REQ-010 SHALL provide port cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge.
REQ-011 SHALL provide port lsb_first  input  1  bit order select; used only per REQ-030.
REQ-012 SHALL provide port miso  input  1  serial data from slave.
REQ-013 SHALL provide port mosi  output  1  serial data to slave.
REQ-014 SHALL provide port sck  output  1  serial clock.
REQ-015 SHALL provide port cs_n  output  NUM_CS  active-low chip selects.
REQ-016 SHALL provide port data_out  output  DATA_WIDTH  last received word.
REQ-017 SHALL provide port busy  output  1  high from cycle after accepted start until transfer end.
REQ-018 SHALL provide port new_data  output  1  one-cycle pulse when data_out updates.

Function
REQ-019 SHALL implement states IDLE, CS_SETUP, TRANSFER, CS_HOLD; IDLE->CS_SETUP on start, CS_SETUP->TRANSFER after CLK_DIV cycles, TRANSFER->CS_HOLD after 2*DATA_WIDTH half-periods, CS_HOLD->IDLE after CLK_DIV cycles.
REQ-020 SHALL latch data_in, cs_sel, cpol, cpha, lsb_first on the clk edge that accepts start; later input changes have no effect on the transfer.
REQ-021 SHALL ignore start whenever busy=1; no queuing.
REQ-022 SHALL assert busy and drive cs_n[cs_sel] low one cycle after accepted start; busy stays high exactly (2*DATA_WIDTH+2)*CLK_DIV cycles.
REQ-023 SHALL keep all cs_n high but still run the full transfer when latched cs_sel >= NUM_CS.
REQ-024 SHALL hold sck at latched cpol outside TRANSFER and toggle it every CLK_DIV cycles in TRANSFER, giving exactly DATA_WIDTH full sck periods.
REQ-025 SHALL, for cpha=0, present first bit on mosi at CS_SETUP entry, sample miso on each leading edge, shift mosi on each trailing edge.
REQ-026 SHALL, for cpha=1, shift mosi on each leading edge (first bit on first leading edge), sample miso on each trailing edge.
REQ-027 SHALL update data_out and pulse new_data for one cycle on the first cycle busy=0 after CS_HOLD; data_out otherwise holds.
REQ-028 SHALL accept a new start in that same new_data cycle (back-to-back), with busy rising the next cycle.

Reset
REQ-029 SHALL, on rst=1 at any time including mid-transfer, enter IDLE next edge with sck=0, mosi=0, cs_n all ones, data_out=0, busy=0, new_data=0, latched cpol=0; the aborted transfer produces no new_data.

Configuration
REQ-030 SHALL, with macro SPI_MASTER_PARAM_LSB_FIRST_EN defined, shift LSB first when latched lsb_first=1 and MSB first when 0, on both mosi and data_out assembly; without the macro, lsb_first is ignored and every transfer is MSB first.

Verification (DATA_WIDTH=8, CLK_DIV=2, NUM_CS=4 unless stated)
REQ-031 SHALL cover: mode 0, cs_sel=1, data_in=0xA5, miso looped to mosi -> cs_n=4'b1101 during transfer, 8 sck rising edges, busy high 36 cycles, new_data pulse with data_out=0xA5.
REQ-032 SHALL cover: mode 3 (cpol=1, cpha=1), data_in=0x3C, miso held 1 -> sck idles high, data_out=0xFF, mosi bit sequence 0,0,1,1,1,1,0,0.
REQ-033 SHALL cover: start re-asserted at busy cycles 5 and 20 -> ignored, single transfer, single new_data.
REQ-034 SHALL cover: rst asserted at cycle 15 of a transfer -> next cycle cs_n=4'hF, busy=0, sck=0, no new_data, data_out=0.
REQ-035 SHALL cover: cs_sel=5 with NUM_CS=4 (width 3 override bench) -> cs_n stays all ones, transfer and new_data still occur.
REQ-036 SHALL cover: with SPI_MASTER_PARAM_LSB_FIRST_EN, lsb_first=1, data_in=0x01, loopback -> first mosi bit 1, data_out=0x01; without macro -> first mosi bit 0, data_out=0x01.

Source files
------------

// File: rtl/spi_master_param.sv
// Parameterised SPI master: one word per transfer, CPOL/CPHA per transfer, NUM_CS chip selects.
// Define SPI_MASTER_PARAM_LSB_FIRST_EN to honour lsb_first; otherwise every transfer is MSB first.
module spi_master_param #(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_DIV    = 13,
   parameter int NUM_CS     = 4,
   parameter int CS_SEL_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [CS_SEL_W-1:0]   cs_sel,
   input  logic                  cpol,
   input  logic                  cpha,
   input  logic                  lsb_first,
   input  logic                  miso,
   output logic                  mosi,
   output logic                  sck,
   output logic [NUM_CS-1:0]     cs_n,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  busy,
   output logic                  new_data
);

   localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int HALF_W = $clog2(2 * DATA_WIDTH);

   typedef enum logic [1:0] {IDLE, CS_SETUP, TRANSFER, CS_HOLD} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q;
   logic [HALF_W-1:0]     half_q;
   logic [DATA_WIDTH-1:0] tx_q, rx_q, data_out_q;
   logic [CS_SEL_W-1:0]   cs_sel_q;
   logic                  cpol_q, cpha_q, sck_q, mosi_q, new_data_q;
   logic [NUM_CS-1:0]     cs_dec;
   logic                  tick, last_half, lsb_in, lsb_eff;
   logic                  accept, edge_evt, shift_evt, sample_evt, done;

`ifdef SPI_MASTER_PARAM_LSB_FIRST_EN
   logic lsb_q;
   assign lsb_in  = lsb_first;
   assign lsb_eff = lsb_q;
`else
   logic unused_lsb;
   assign unused_lsb = lsb_first;
   assign lsb_in     = 1'b0;
   assign lsb_eff    = 1'b0;
`endif

   assign tick      = (cnt_q == CNT_W'(CLK_DIV - 1));
   assign last_half = (half_q == HALF_W'(2 * DATA_WIDTH - 1));

   // Out-of-range selects match no line, so every cs_n stays high.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CS; gi++) begin : g_cs
         assign cs_dec[gi] = (cs_sel_q != CS_SEL_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (start) state_d = CS_SETUP;
         CS_SETUP: if (tick) state_d = TRANSFER;
         TRANSFER: if (tick && last_half) state_d = CS_HOLD;
         CS_HOLD:  if (tick) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      busy     = 1'b0;
      cs_n     = '1;
      accept   = 1'b0;
      edge_evt = 1'b0;
      done     = 1'b0;
      case (state_q)
         IDLE:     accept = start;
         CS_SETUP: begin busy = 1'b1; cs_n = cs_dec; end
         TRANSFER: begin busy = 1'b1; cs_n = cs_dec; edge_evt = tick; end
         CS_HOLD:  begin busy = 1'b1; cs_n = cs_dec; done = tick; end
         default:  ;
      endcase
      // Even half-periods end on a leading edge, odd ones on a trailing edge.
      shift_evt  = edge_evt & (cpha_q ? ~half_q[0] : half_q[0]);
      sample_evt = edge_evt & (cpha_q ? half_q[0] : ~half_q[0]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         half_q     <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         data_out_q <= '0;
         cs_sel_q   <= '0;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         sck_q      <= 1'b0;
         mosi_q     <= 1'b0;
         new_data_q <= 1'b0;
`ifdef SPI_MASTER_PARAM_LSB_FIRST_EN
         lsb_q      <= 1'b0;
`endif
      end else begin
         new_data_q <= done;
         if (done) data_out_q <= rx_q;
         if (state_q == IDLE || tick) cnt_q <= '0;
         else                         cnt_q <= cnt_q + CNT_W'(1);
         if (state_q != TRANSFER) half_q <= '0;
         else if (tick)           half_q <= half_q + HALF_W'(1);
         if (accept) begin
            cs_sel_q <= cs_sel;
            cpol_q   <= cpol;
            cpha_q   <= cpha;
            sck_q    <= cpol;
            rx_q     <= '0;
`ifdef SPI_MASTER_PARAM_LSB_FIRST_EN
            lsb_q    <= lsb_first;
`endif
            if (cpha) begin
               mosi_q <= 1'b0;
               tx_q   <= data_in;
            end else begin
               mosi_q <= lsb_in ? data_in[0] : data_in[DATA_WIDTH-1];
               tx_q   <= lsb_in ? (data_in >> 1) : (data_in << 1);
            end
         end
         if (edge_evt) sck_q <= ~sck_q;
         if (shift_evt) begin
            mosi_q <= lsb_eff ? tx_q[0] : tx_q[DATA_WIDTH-1];
            tx_q   <= lsb_eff ? (tx_q >> 1) : (tx_q << 1);
         end
         if (sample_evt)
            rx_q <= lsb_eff ? {miso, rx_q[DATA_WIDTH-1:1]} : {rx_q[DATA_WIDTH-2:0], miso};
      end
   end

   assign mosi     = mosi_q;
   assign sck      = sck_q;
   assign data_out = data_out_q;
   assign new_data = new_data_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param (DATA_WIDTH=8, CLK_DIV=2, NUM_CS=4, 3-bit cs_sel).
module tb_spi_master_param;

   logic       clk = 1'b0;
   logic       rst, start, cpol, cpha, lsb_first, miso;
   logic [7:0] data_in;
   logic [2:0] cs_sel;
   logic       mosi, sck, busy, new_data;
   logic [3:0] cs_n;
   logic [7:0] data_out;
   logic       loop, miso_fix;

   int compared = 0, mismatched = 0;
   int sck_rises = 0, busy_cycles = 0, nd_pulses = 0;
   int b0, r0, n0;
   logic [7:0] mosi_hist = '0;
   logic       sck_prev = 1'b0;
   logic       exp_first;
   logic [7:0] exp_hist;

   assign miso = loop ? mosi : miso_fix;

   spi_master_param #(.DATA_WIDTH(8), .CLK_DIV(2), .NUM_CS(4), .CS_SEL_W(3)) dut (
      .clk(clk), .rst(rst), .start(start), .data_in(data_in), .cs_sel(cs_sel),
      .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .miso(miso),
      .mosi(mosi), .sck(sck), .cs_n(cs_n), .data_out(data_out),
      .busy(busy), .new_data(new_data)
   );

   always #5 clk = ~clk;

   // Passive monitor: mosi is recorded on every sck rising edge.
   always @(negedge clk) begin
      if (sck && !sck_prev) begin
         sck_rises++;
         mosi_hist = {mosi_hist[6:0], mosi};
      end
      sck_prev = sck;
      if (busy) busy_cycles++;
      if (new_data) nd_pulses++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_xfer(input logic [7:0] d, input logic [2:0] sel,
                             input logic pol, input logic pha, input logic lsb);
      data_in = d; cs_sel = sel; cpol = pol; cpha = pha; lsb_first = lsb;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (new_data === 1'b1) break;
      end
      check(tag, new_data, 1);
      #2;
   endtask

   task automatic snap();
      b0 = busy_cycles; r0 = sck_rises; n0 = nd_pulses;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; data_in = '0; cs_sel = '0;
      cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; loop = 1'b1; miso_fix = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cs_n", cs_n, 4'hF);
      check("rst_busy", busy, 0);
      check("rst_sck", sck, 0);
      check("rst_mosi", mosi, 0);
      check("rst_data_out", data_out, 8'h00);
      check("rst_new_data", new_data, 0);
      rst = 1'b0;
      @(negedge clk); #2;

      // Mode 0, slave 1, loopback; inputs scrambled after accept must not matter.
      snap();
      start_xfer(8'hA5, 3'd1, 1'b0, 1'b0, 1'b0);
      check("m0_busy", busy, 1);
      check("m0_cs_n", cs_n, 4'hD);
      check("m0_sck_setup", sck, 0);
      check("m0_first_mosi", mosi, 1);
      data_in = 8'h00; cs_sel = 3'd2; cpol = 1'b1; cpha = 1'b1;
      @(negedge clk);
      check("m0_cs_n_latched", cs_n, 4'hD);
      wait_done("m0_done");
      check("m0_busy_low", busy, 0);
      check("m0_data_out", data_out, 8'hA5);
      check("m0_busy_cycles", busy_cycles - b0, 36);
      check("m0_sck_rises", sck_rises - r0, 8);
      check("m0_nd_pulses", nd_pulses - n0, 1);
      check("m0_mosi_bits", mosi_hist, 8'hA5);

      // Mode 3 issued back-to-back in the new_data cycle, miso held high.
      snap();
      loop = 1'b0; miso_fix = 1'b1;
      start_xfer(8'h3C, 3'd2, 1'b1, 1'b1, 1'b0);
      check("m3_b2b_busy", busy, 1);
      check("m3_cs_n", cs_n, 4'hB);
      check("m3_sck_idle_hi", sck, 1);
      wait_done("m3_done");
      check("m3_data_out", data_out, 8'hFF);
      check("m3_mosi_bits", mosi_hist, 8'h3C);
      check("m3_sck_after", sck, 1);
      check("m3_cs_n_after", cs_n, 4'hF);
      check("m3_busy_cycles", busy_cycles - b0, 36);

      // Start re-asserted while busy is ignored.
      loop = 1'b1;
      @(negedge clk); #2;
      snap();
      start_xfer(8'h5A, 3'd0, 1'b0, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      data_in = 8'hFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      data_in = 8'h0F; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("ign_done");
      check("ign_data_out", data_out, 8'h5A);
      check("ign_busy_cycles", busy_cycles - b0, 36);
      repeat (40) @(negedge clk);
      #2;
      check("ign_nd_pulses", nd_pulses - n0, 1);
      check("ign_busy_idle", busy, 0);

      // Reset during busy cycle 15 aborts cleanly.
      snap();
      start_xfer(8'hC3, 3'd3, 1'b1, 1'b0, 1'b0);
      check("rst_mid_cs_n_active", cs_n, 4'h7);
      repeat (14) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_cs_n", cs_n, 4'hF);
      check("abort_busy", busy, 0);
      check("abort_sck", sck, 0);
      check("abort_new_data", new_data, 0);
      check("abort_data_out", data_out, 8'h00);
      check("abort_mosi", mosi, 0);
      rst = 1'b0;
      repeat (45) @(negedge clk);
      #2;
      check("abort_no_nd", nd_pulses - n0, 0);
      check("abort_data_out_hold", data_out, 8'h00);

      // Out-of-range chip select: no line asserted, transfer still runs.
      snap();
      start_xfer(8'h96, 3'd5, 1'b0, 1'b0, 1'b0);
      check("cs5_busy", busy, 1);
      check("cs5_cs_n_start", cs_n, 4'hF);
      repeat (17) @(negedge clk);
      check("cs5_cs_n_mid", cs_n, 4'hF);
      wait_done("cs5_done");
      check("cs5_data_out", data_out, 8'h96);
      check("cs5_busy_cycles", busy_cycles - b0, 36);

      // Bit order request.
`ifdef SPI_MASTER_PARAM_LSB_FIRST_EN
      exp_first = 1'b1; exp_hist = 8'h80;
`else
      exp_first = 1'b0; exp_hist = 8'h01;
`endif
      start_xfer(8'h01, 3'd0, 1'b0, 1'b0, 1'b1);
      check("lsb_first_mosi", mosi, exp_first);
      wait_done("lsb_done");
      check("lsb_data_out", data_out, 8'h01);
      check("lsb_mosi_bits", mosi_hist, exp_hist);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
